// File: rtl/definitions_pkg.sv
// Shared types and elaboration helpers for the binary to 7-segment converter.
// Segment codes are active-low, bit order {g,f,e,d,c,b,a}.
package definitions_pkg;

    localparam int DEF_DW = 16;

    typedef enum logic [6:0] {
        ZERO  = 7'h40,
        ONE   = 7'h79,
        TWO   = 7'h24,
        TREE  = 7'h30,
        FOUR  = 7'h19,
        FIVE  = 7'h12,
        SIX   = 7'h02,
        SEVEN = 7'h78,
        EIGHT = 7'h00,
        NINE  = 7'h10,
        SIGN  = 7'h3F,
        OFF   = 7'h7F
    } segment_e;

    typedef enum logic [1:0] {
        IDLE,
        PROCESING,
        READY
    } state_e;

    typedef logic [3:0] bcd_t;
    typedef logic [6:0] disp_seg_t;

    function automatic int cnt_width(input int dw);
        return (dw > 1) ? $clog2(dw) : 1;
    endfunction

    localparam int CNT_W = cnt_width(DEF_DW);

    // Smallest n with 10^n >= 2^dw, i.e. ceil(dw*log10(2)) without reals.
    function automatic int min_digits(input int dw);
        logic [127:0] lim;
        logic [127:0] pw;
        int n;
        lim = 128'd1 << dw;
        pw  = 128'd1;
        n   = 0;
        while (pw < lim) begin
            pw = pw * 128'd10;
            n++;
        end
        return n;
    endfunction

endpackage

// File: rtl/bcd_to_seg.sv
// Combinational decode of one BCD digit into its active-low 7-segment pattern.
module bcd_to_seg
    import definitions_pkg::*;
(
    input  bcd_t      bcd_i,
    output disp_seg_t seg_o
);

    always_comb begin
        seg_o = OFF;
        case (bcd_i)
            4'd0:    seg_o = ZERO;
            4'd1:    seg_o = ONE;
            4'd2:    seg_o = TWO;
            4'd3:    seg_o = TREE;
            4'd4:    seg_o = FOUR;
            4'd5:    seg_o = FIVE;
            4'd6:    seg_o = SIX;
            4'd7:    seg_o = SEVEN;
            4'd8:    seg_o = EIGHT;
            4'd9:    seg_o = NINE;
            default: seg_o = OFF;
        endcase
    end

endmodule

// File: rtl/bin_to_seg_conv.sv
// Sequential double-dabble binary to BCD converter with 7-segment output,
// optional sign handling and leading-zero blanking.
module bin_to_seg_conv
    import definitions_pkg::*;
#(
    parameter int DW       = 16,
    parameter int NDIG     = 5,
    parameter int SIGNED   = 1,
    parameter int BLANK_LZ = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [DW-1:0]         data_i,
    output logic                  busy_o,
    output logic                  ready_o,
    output logic                  neg_o,
    output logic [NDIG*4-1:0]     bcd_o,
    output logic [(NDIG+1)*7-1:0] seg_o
);

    localparam int CW = cnt_width(DW);
    localparam int BW = NDIG * 4;

    generate
        if (NDIG < min_digits(DW)) begin : g_ndig_check
            $error("bin_to_seg_conv: NDIG too small for DW");
        end
    endgenerate

    state_e                  state_q, state_d;
    logic [BW-1:0]           bcd_q;
    logic [BW-1:0]           bcd_adj;
    logic [DW-1:0]           mag_q;
    logic [DW-1:0]           mag_in;
    logic                    neg_in;
    logic                    sign_q;
    logic [CW-1:0]           cnt_q;
    disp_seg_t               dig_seg [NDIG];
    logic [(NDIG+1)*7-1:0]   seg_d;
    logic                    nz_seen;

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        busy_o  = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) state_d = PROCESING;
            end
            PROCESING: begin
                busy_o = 1'b1;
                if (cnt_q == CW'(DW - 1)) state_d = READY;
            end
            READY: begin
                busy_o  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Unsigned DW-bit negation keeps -2^(DW-1) representable as its magnitude.
    always_comb begin
        neg_in = (SIGNED != 0) && data_i[DW-1];
        mag_in = neg_in ? ('0 - data_i) : data_i;
    end

    always_comb begin
        bcd_adj = bcd_q;
        for (int unsigned i = 0; i < NDIG; i++) begin
            if (bcd_q[i*4 +: 4] >= 4'd5) bcd_adj[i*4 +: 4] = bcd_q[i*4 +: 4] + 4'd3;
        end
    end

    generate
        for (genvar g = 0; g < NDIG; g++) begin : g_dig
            bcd_to_seg u_bcd_to_seg (
                .bcd_i (bcd_q[g*4 +: 4]),
                .seg_o (dig_seg[g])
            );
        end
    endgenerate

    // Walk from the most-significant digit down; digit 0 is never blanked.
    always_comb begin
        seg_d   = '1;
        nz_seen = 1'b0;
        for (int unsigned k = 0; k < NDIG; k++) begin
            if (bcd_q[(NDIG-1-k)*4 +: 4] != 4'd0) nz_seen = 1'b1;
            if ((BLANK_LZ != 0) && !nz_seen && (k != NDIG - 1))
                seg_d[(NDIG-1-k)*7 +: 7] = OFF;
            else
                seg_d[(NDIG-1-k)*7 +: 7] = dig_seg[NDIG-1-k];
        end
        seg_d[NDIG*7 +: 7] = ((SIGNED != 0) && sign_q) ? SIGN : OFF;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bcd_q   <= '0;
            mag_q   <= '0;
            sign_q  <= 1'b0;
            cnt_q   <= '0;
            ready_o <= 1'b0;
            neg_o   <= 1'b0;
            bcd_o   <= '0;
            seg_o   <= '1;
        end else begin
            ready_o <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        mag_q  <= mag_in;
                        sign_q <= neg_in;
                        bcd_q  <= '0;
                        cnt_q  <= '0;
                    end
                end
                PROCESING: begin
                    {bcd_q, mag_q} <= {bcd_adj, mag_q} << 1;
                    cnt_q          <= cnt_q + 1'b1;
                end
                READY: begin
                    bcd_o   <= bcd_q;
                    neg_o   <= sign_q;
                    seg_o   <= seg_d;
                    ready_o <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_bin_to_seg_conv.sv
// Scoreboard bench for bin_to_seg_conv (DW=16, NDIG=5, signed, blanking on).
module tb_bin_to_seg_conv;

    localparam int DW   = 16;
    localparam int NDIG = 5;
    localparam int SW   = (NDIG + 1) * 7;

    logic            clk = 1'b0;
    logic            rst;
    logic            start;
    logic [DW-1:0]   data_i;
    logic            busy_o;
    logic            ready_o;
    logic            neg_o;
    logic [NDIG*4-1:0] bcd_o;
    logic [SW-1:0]   seg_o;

    bin_to_seg_conv #(
        .DW       (DW),
        .NDIG     (NDIG),
        .SIGNED   (1),
        .BLANK_LZ (1)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .data_i  (data_i),
        .busy_o  (busy_o),
        .ready_o (ready_o),
        .neg_o   (neg_o),
        .bcd_o   (bcd_o),
        .seg_o   (seg_o)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    typedef struct {
        int                cyc;
        logic [NDIG*4-1:0] bcd;
        logic              neg;
        logic [SW-1:0]     seg;
    } exp_t;

    exp_t q[$];
    int n_checks = 0;
    int n_fail   = 0;

    localparam logic [6:0] SEG_OFF   = 7'h7F;
    localparam logic [6:0] SEG_MINUS = 7'h3F;
    logic [6:0] seg_tbl [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                                 7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Decimal reference: digits by division, blanking above the top nonzero digit.
    function automatic exp_t model(input logic [DW-1:0] d);
        exp_t e;
        int v, mag, top;
        int dig [NDIG];
        v     = int'($signed(d));
        e.neg = (v < 0);
        mag   = (v < 0) ? -v : v;
        e.bcd = '0;
        e.seg = '0;
        e.cyc = 0;
        top   = 0;
        for (int i = 0; i < NDIG; i++) begin
            dig[i] = mag % 10;
            mag    = mag / 10;
            e.bcd[i*4 +: 4] = 4'(dig[i]);
            if (dig[i] != 0) top = i;
        end
        for (int i = 0; i < NDIG; i++)
            e.seg[i*7 +: 7] = (i > top) ? SEG_OFF : seg_tbl[dig[i]];
        e.seg[NDIG*7 +: 7] = e.neg ? SEG_MINUS : SEG_OFF;
        return e;
    endfunction

    // Monitor: compare every ready pulse with the oldest expected result.
    always @(negedge clk) begin
        exp_t e;
        if (ready_o) begin
            if (q.size() == 0) begin
                chk("spurious_ready", 64'(ready_o), 64'd0);
            end else begin
                e = q.pop_front();
                chk("ready_cycle", 64'(cyc), 64'(e.cyc));
                chk("bcd_o", 64'(bcd_o), 64'(e.bcd));
                chk("neg_o", 64'(neg_o), 64'(e.neg));
                chk("seg_o", 64'(seg_o), 64'(e.seg));
            end
        end else if (q.size() > 0 && cyc > q[0].cyc) begin
            chk("ready_by_deadline", 64'(ready_o), 64'd1);
            void'(q.pop_front());
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [DW-1:0] d, input bit push);
        exp_t e;
        int budget;
        budget = 0;
        while (busy_o && budget < 100) begin
            tick();
            budget++;
        end
        if (budget >= 100) chk("idle_wait", 64'(busy_o), 64'd0);
        start  = 1'b1;
        data_i = d;
        if (push) begin
            e     = model(d);
            e.cyc = cyc + 18;
            q.push_back(e);
        end
        tick();
        start  = 1'b0;
        data_i = 16'(($urandom));
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, "_busy"},  64'(busy_o),  64'd0);
        chk({tag, "_ready"}, 64'(ready_o), 64'd0);
        chk({tag, "_neg"},   64'(neg_o),   64'd0);
        chk({tag, "_bcd"},   64'(bcd_o),   64'd0);
        chk({tag, "_seg"},   64'(seg_o),   64'({SW{1'b1}}));
    endtask

    initial begin
        logic [DW-1:0] d;
        rst    = 1'b1;
        start  = 1'b0;
        data_i = '0;
        repeat (3) tick();
        @(negedge clk);
        check_reset_values("reset");
        tick();
        rst = 1'b0;

        issue(16'd12345, 1'b1);
        issue(16'hFFFF, 1'b1);
        issue(16'h8000, 1'b1);
        issue(16'd0, 1'b1);
        issue(16'd32767, 1'b1);

        // Start re-pulsed in cycles 3 and 10 of a conversion must be ignored.
        issue(16'd100, 1'b1);
        tick(); tick();
        chk("busy_c3", 64'(busy_o), 64'd1);
        start = 1'b1; data_i = 16'd999;
        tick();
        start = 1'b0;
        repeat (6) tick();
        chk("busy_c10", 64'(busy_o), 64'd1);
        start = 1'b1; data_i = 16'd999;
        tick();
        start = 1'b0;

        // Reset in cycle 8 aborts; start in the very next cycle is accepted.
        issue(16'd30000, 1'b0);
        repeat (7) tick();
        rst = 1'b1;
        tick();
        rst    = 1'b0;
        start  = 1'b1;
        data_i = 16'd42;
        begin
            exp_t e;
            e     = model(16'd42);
            e.cyc = cyc + 18;
            q.push_back(e);
        end
        @(negedge clk);
        check_reset_values("abort");
        tick();
        start = 1'b0;

        for (int n = 0; n < 150; n++) begin
            case ($urandom_range(0, 3))
                0:       d = 16'($urandom_range(0, 20));
                1:       d = 16'(-int'($urandom_range(1, 20)));
                default: d = 16'($urandom);
            endcase
            issue(d, 1'b1);
            repeat ($urandom_range(0, 2)) tick();
        end

        repeat (40) tick();
        chk("queue_empty", 64'(q.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/bin_to_seg_conv.md
BIN_TO_SEG_CONV -- requirements
Module: bin_to_seg_conv

Interface
REQ-001 The block SHALL have parameter DW, default 16, binary input width.
REQ-002 The block SHALL have parameter NDIG, default 5, number of BCD digits, which SHALL be at least ceil(DW*log10(2)); elaboration SHALL fail otherwise.
REQ-003 The block SHALL have parameter SIGNED, default 1; 1 means data_i is two's complement, 0 means unsigned.
REQ-004 The block SHALL have parameter BLANK_LZ, default 1; 1 means leading-zero digits are blanked.
REQ-005 The block SHALL have one clock and a synchronous, active-high reset.
REQ-006 clk  in  1  rising-edge clock.
REQ-007 rst  in  1  synchronous active-high reset.
REQ-008 start  in  1  conversion request, sampled in IDLE only.
REQ-009 data_i  in  DW  binary operand.
REQ-010 busy_o  out  1  high while a conversion is in progress.
REQ-011 ready_o  out  1  one-cycle completion pulse.
REQ-012 neg_o  out  1  registered sign of the last result.
REQ-013 bcd_o  out  NDIG*4  registered BCD magnitude; nibble 0 is the units digit.
REQ-014 seg_o  out  (NDIG+1)*7  registered active-low 7-segment patterns; slots 0..NDIG-1 are digits and slot NDIG is the sign.

Function
REQ-015 The FSM SHALL have the states IDLE, PROCESING and READY.
REQ-016 In IDLE with start=1, the block SHALL capture the magnitude of data_i (negated if SIGNED=1 and MSB=1), capture the sign, clear the BCD shift register, clear the bit counter, and enter PROCESING.
REQ-017 Each PROCESING cycle SHALL first add 3 to every BCD nibble >=5, then shift {BCD, magnitude} left by 1.
REQ-018 PROCESING SHALL last exactly DW cycles; when the counter equals DW-1 the FSM SHALL enter READY.
REQ-019 In READY, bcd_o, neg_o and seg_o SHALL be loaded together, ready_o SHALL be 1 for that cycle only, and the FSM SHALL return to IDLE.
REQ-020 Latency SHALL be fixed: start accepted at edge 0 gives ready_o high in cycle DW+1.
REQ-021 busy_o SHALL be 1 in PROCESING and READY.
REQ-022 start SHALL be ignored in PROCESING and READY; no queuing.
REQ-023 Outputs SHALL hold the last result until the next READY.
REQ-024 Magnitude arithmetic SHALL be DW-bit unsigned, so the most negative input -2^(DW-1) yields magnitude 2^(DW-1) without overflow.
REQ-025 Digit decoding SHALL map 0..9 to the ZERO..NINE patterns; nibbles >9 cannot occur.
REQ-026 With BLANK_LZ=1, every zero digit above the most-significant nonzero digit SHALL be OFF, and digit 0 SHALL always be displayed (value 0 shows ZERO).
REQ-027 With BLANK_LZ=0, all digits SHALL be displayed.
REQ-028 The sign slot SHALL be SIGN when neg_o=1, else OFF; it SHALL always be OFF when SIGNED=0.
REQ-029 neg_o SHALL never be 1 for a zero result.

Reset
REQ-030 rst SHALL have priority over all other activity.
REQ-031 On rst=1, the FSM SHALL be IDLE, busy_o=0, ready_o=0, neg_o=0, bcd_o=0, and every seg_o slot SHALL be OFF.
REQ-032 A reset mid-conversion SHALL abort the conversion with no ready_o pulse; the first cycle after reset SHALL accept start.

Structure
REQ-033 segment_e, state_e, bcd_t, disp_seg_t and a counter width localparam ($clog2(DW)) SHALL live in definitions_pkg.
REQ-034 A combinational sub-module bcd_to_seg (bcd_t in, disp_seg_t out) SHALL be instantiated NDIG times.
REQ-035 The FSM, shift datapath, blanking logic and output registers SHALL reside in bin_to_seg_conv.

Verification (DW=16, NDIG=5, SIGNED=1, BLANK_LZ=1)
REQ-036 start with data_i=16'd12345 (value 12345) -> ready_o pulse in cycle 17; bcd_o=20'h12345; digits ONE,TWO,TREE,FOUR,FIVE (most- to least-significant); sign OFF; neg_o=0.
REQ-037 data_i=16'hFFFF (value -1) -> bcd_o=20'h00001; neg_o=1; digit0 ONE; digits 1..4 OFF; sign slot SIGN.
REQ-038 data_i=16'h8000 (value -32768) -> bcd_o=20'h32768; neg_o=1; sign slot SIGN.
REQ-039 data_i=0 -> bcd_o=0; digit0 ZERO; digits 1..4 OFF; sign OFF; neg_o=0.
REQ-040 data_i=16'd100, with start re-pulsed with 16'd999 in cycles 3 and 10 -> exactly one ready_o pulse; bcd_o=20'h00100.
REQ-041 rst asserted in cycle 8 of a conversion -> next cycle all outputs at reset values and no ready_o; a new start with 16'd42 then gives bcd_o=20'h00042 in cycle 17 after it.
